// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers of the 5-stage core:
// slot control encoding and one packed payload struct per stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD,
    SLOT_DROP,
    SLOT_CLEAR
  } slot_op_e;

  typedef struct packed {
    logic [31:0] instro;
    logic [31:0] pcAddrOuto;
    logic [31:0] npco;
  } ifid_t;

  typedef struct packed {
    logic [31:0] rdat1o;
    logic [31:0] rdat2o;
    logic [31:0] immo;
    logic [3:0]  aluopo;
    logic        alusrco;
    logic        dWENo;
    logic        dRENo;
    logic        WENo;
    logic [4:0]  wselo;
    logic [1:0]  reg_wro;
    logic [1:0]  write_sigo;
    logic        halto;
    logic        beqo;
    logic        bneo;
    logic        jsigo;
    logic        jrsigo;
    logic [31:0] pcAddrOuto;
    logic [25:0] jaddro;
  } idex_t;

  typedef struct packed {
    logic [31:0] outputo;
    logic        zeroo;
    logic [31:0] wdato;
    logic        dWENo;
    logic        dRENo;
    logic        WENo;
    logic [4:0]  wselo;
    logic [1:0]  reg_wro;
    logic [1:0]  write_sigo;
    logic        halto;
    logic [31:0] brvalo;
    logic        beqo;
    logic        bneo;
    logic        jsigo;
    logic        jrsigo;
    logic [31:0] pcAddrOuto;
    logic [31:0] laddro;
  } exmem_t;

  typedef struct packed {
    logic [31:0] outputo;
    logic [31:0] dloado;
    logic        WENo;
    logic [4:0]  wselo;
    logic [1:0]  reg_wro;
    logic        halto;
    logic [31:0] pcAddrOuto;
    logic [31:0] laddro;
  } memwb_t;

  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

endpackage

// File: rtl/pipe_slot.sv
// One payload slot: a WIDTH-bit data register plus its valid bit, driven by
// a single hold/load/drop/clear command from the owning stage.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int CLEAR_DATA = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  slot_op_e         op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A drop only retires the entry; the stale payload stays until overwritten.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (op_i)
      SLOT_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
      SLOT_DROP: begin
        valid_d = 1'b0;
      end
      SLOT_CLEAR: begin
        valid_d = 1'b0;
        if (CLEAR_DATA != 0) data_d = '0;
      end
      default: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      if (CLEAR_DATA != 0) data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register between two core stages, with an
// optional skid slot that breaks the ready path, flush, freeze and stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             mainValid, skidValid;
  logic [WIDTH-1:0] mainData, skidData, mainLoadData;
  slot_op_e         mainOp, skidOp;
  logic             inFire, outFire;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  // With a skid slot, in_ready depends on registered state only.
  assign in_ready  = en & ((SKID != 0) ? !skidValid : (!mainValid | out_ready));
  assign out_valid = en & mainValid;
  assign out_data  = mainData;
  assign stall_cnt = stallCnt_q;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_comb begin
    mainOp       = SLOT_HOLD;
    skidOp       = SLOT_HOLD;
    mainLoadData = in_data;
    if (flush) begin
      mainOp = SLOT_CLEAR;
      skidOp = SLOT_CLEAR;
    end else if (en) begin
      if (SKID == 0) begin
        if (inFire)       mainOp = SLOT_LOAD;
        else if (outFire) mainOp = SLOT_DROP;
      end else if (!mainValid) begin
        if (inFire) mainOp = SLOT_LOAD;
      end else if (outFire) begin
        // Skid entry is older than anything upstream, so it moves up first.
        if (skidValid) begin
          mainOp       = SLOT_LOAD;
          mainLoadData = skidData;
          skidOp       = SLOT_DROP;
        end else if (inFire) begin
          mainOp = SLOT_LOAD;
        end else begin
          mainOp = SLOT_DROP;
        end
      end else if (inFire) begin
        skidOp = SLOT_LOAD;
      end
    end
  end

  pipe_slot #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk_i   (CLK),
    .rst_i   (RST),
    .op_i    (mainOp),
    .data_i  (mainLoadData),
    .valid_o (mainValid),
    .data_o  (mainData)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
      ) u_skid (
        .clk_i   (CLK),
        .rst_i   (RST),
        .op_i    (skidOp),
        .data_i  (in_data),
        .valid_o (skidValid),
        .data_o  (skidData)
      );
    end else begin : g_noskid
      logic unusedSkidOp;
      assign unusedSkidOp = ^skidOp;
      assign skidValid    = 1'b0;
      assign skidData     = '0;
    end
  endgenerate

  // Counts cycles the stage holds a payload the consumer refuses; never wraps.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (en && mainValid && !out_ready && !flush && (stallCnt_q != {CNT_W{1'b1}}))
      stallCnt_d = stallCnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) stallCnt_q <= '0;
    else     stallCnt_q <= stallCnt_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a WIDTH=8 skid stage for the main flow,
// plus a skid/no-skid pair with a 2-bit stall counter driven in lockstep.
module tb_pipe_stage_reg;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int totalChecks = 0;
  int badChecks   = 0;

  logic       aRst, aFlush, aEn, aInValid, aOutReady;
  logic [7:0] aInData;
  logic       aInReady, aOutValid;
  logic [7:0] aOutData;
  logic [15:0] aStall;

  logic       bRst, bFlush, bEn, bInValid, bOutReady;
  logic [7:0] bInData;
  logic       bInReady, bOutValid, cInReady, cOutValid;
  logic [7:0] bOutData, cOutData;
  logic [1:0] bStall, cStall;

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) dutA (
    .CLK(CLK), .RST(aRst), .flush(aFlush), .en(aEn),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .stall_cnt(aStall)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .CLEAR_DATA(1), .CNT_W(2)) dutB (
    .CLK(CLK), .RST(bRst), .flush(bFlush), .en(bEn),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .stall_cnt(bStall)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(0), .CLEAR_DATA(1), .CNT_W(2)) dutC (
    .CLK(CLK), .RST(bRst), .flush(bFlush), .en(bEn),
    .in_valid(bInValid), .in_ready(cInReady), .in_data(bInData),
    .out_valid(cOutValid), .out_ready(bOutReady), .out_data(cOutData),
    .stall_cnt(cStall)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    aRst = 1'b1; aFlush = 1'b0; aEn = 1'b1; aInValid = 1'b1; aInData = 8'hAA; aOutReady = 1'b0;
    bRst = 1'b1; bFlush = 1'b0; bEn = 1'b1; bInValid = 1'b0; bInData = 8'h00; bOutReady = 1'b0;
    tick();
    tick();
    totalChecks++;
    if (aOutValid !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_valid got=%b exp=0", aOutValid); end
    totalChecks++;
    if (aOutData !== 8'h00) begin badChecks++; $display("[TB] FAIL reset_data got=%h exp=00", aOutData); end
    totalChecks++;
    if (aStall !== 16'd0) begin badChecks++; $display("[TB] FAIL reset_stall got=%0d exp=0", aStall); end
    aRst = 1'b0; aInValid = 1'b0; bRst = 1'b0;
    #1;
    totalChecks++;
    if (aInReady !== 1'b1) begin badChecks++; $display("[TB] FAIL reset_inready got=%b exp=1", aInReady); end
  endtask

  task automatic test_stream;
    aOutReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      aInValid = 1'b1;
      aInData  = 8'(i);
      tick();
      totalChecks++;
      if (aOutValid !== 1'b1 || aOutData !== 8'(i)) begin
        badChecks++;
        $display("[TB] FAIL stream_out[%0d] got v=%b d=%h exp v=1 d=%h", i, aOutValid, aOutData, 8'(i));
      end
      totalChecks++;
      if (aInReady !== 1'b1) begin badChecks++; $display("[TB] FAIL stream_inready[%0d] got=%b exp=1", i, aInReady); end
    end
    aInValid = 1'b0;
    tick();
    totalChecks++;
    if (aOutValid !== 1'b0) begin badChecks++; $display("[TB] FAIL stream_drain got=%b exp=0", aOutValid); end
    totalChecks++;
    if (aStall !== 16'd0) begin badChecks++; $display("[TB] FAIL stream_stall got=%0d exp=0", aStall); end
  endtask

  task automatic test_backpressure;
    aOutReady = 1'b0;
    aInValid  = 1'b1;
    aInData   = 8'h11;
    tick();
    aInData = 8'h22;
    #1;
    totalChecks++;
    if (aInReady !== 1'b1) begin badChecks++; $display("[TB] FAIL bp_ready_first got=%b exp=1", aInReady); end
    tick();
    aInValid = 1'b0;
    totalChecks++;
    if (aInReady !== 1'b0) begin badChecks++; $display("[TB] FAIL bp_ready_full got=%b exp=0", aInReady); end
    totalChecks++;
    if (aStall !== 16'd1) begin badChecks++; $display("[TB] FAIL bp_stall1 got=%0d exp=1", aStall); end
    tick();
    totalChecks++;
    if (aStall !== 16'd2) begin badChecks++; $display("[TB] FAIL bp_stall2 got=%0d exp=2", aStall); end
    tick();
    totalChecks++;
    if (aStall !== 16'd3) begin badChecks++; $display("[TB] FAIL bp_stall3 got=%0d exp=3", aStall); end
    totalChecks++;
    if (aOutData !== 8'h11) begin badChecks++; $display("[TB] FAIL bp_hold got=%h exp=11", aOutData); end
    aOutReady = 1'b1;
    tick();
    totalChecks++;
    if (aOutValid !== 1'b1 || aOutData !== 8'h22) begin
      badChecks++;
      $display("[TB] FAIL bp_second got v=%b d=%h exp v=1 d=22", aOutValid, aOutData);
    end
    totalChecks++;
    if (aInReady !== 1'b1) begin badChecks++; $display("[TB] FAIL bp_ready_back got=%b exp=1", aInReady); end
    totalChecks++;
    if (aStall !== 16'd3) begin badChecks++; $display("[TB] FAIL bp_stall_hold got=%0d exp=3", aStall); end
    tick();
    totalChecks++;
    if (aOutValid !== 1'b0) begin badChecks++; $display("[TB] FAIL bp_empty got=%b exp=0", aOutValid); end
  endtask

  task automatic test_flush;
    aOutReady = 1'b0;
    aInValid  = 1'b1;
    aInData   = 8'h33;
    tick();
    aInData = 8'h44;
    tick();
    totalChecks++;
    if (aOutData !== 8'h33 || aInReady !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL flush_setup got d=%h rdy=%b exp d=33 rdy=0", aOutData, aInReady);
    end
    aFlush  = 1'b1;
    aInData = 8'h55;
    tick();
    aFlush   = 1'b0;
    aInValid = 1'b0;
    totalChecks++;
    if (aOutValid !== 1'b0 || aOutData !== 8'h00) begin
      badChecks++;
      $display("[TB] FAIL flush_clear got v=%b d=%h exp v=0 d=00", aOutValid, aOutData);
    end
    totalChecks++;
    if (aStall !== 16'd4) begin badChecks++; $display("[TB] FAIL flush_stall got=%0d exp=4", aStall); end
    tick();
    totalChecks++;
    if (aOutValid !== 1'b0) begin badChecks++; $display("[TB] FAIL flush_drop55 got=%b exp=0", aOutValid); end
    aInValid  = 1'b1;
    aInData   = 8'h66;
    aOutReady = 1'b1;
    tick();
    aInValid = 1'b0;
    totalChecks++;
    if (aOutValid !== 1'b1 || aOutData !== 8'h66) begin
      badChecks++;
      $display("[TB] FAIL flush_after got v=%b d=%h exp v=1 d=66", aOutValid, aOutData);
    end
    tick();
  endtask

  task automatic test_enable;
    aOutReady = 1'b0;
    aInValid  = 1'b1;
    aInData   = 8'h77;
    tick();
    aInData   = 8'h99;
    aEn       = 1'b0;
    aOutReady = 1'b1;
    #1;
    totalChecks++;
    if (aOutValid !== 1'b0 || aInReady !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL en_gate got v=%b rdy=%b exp v=0 rdy=0", aOutValid, aInReady);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      totalChecks++;
      if (aOutValid !== 1'b0 || aInReady !== 1'b0 || aOutData !== 8'h77 || aStall !== 16'd4) begin
        badChecks++;
        $display("[TB] FAIL en_freeze[%0d] got v=%b rdy=%b d=%h cnt=%0d exp v=0 rdy=0 d=77 cnt=4",
                 i, aOutValid, aInReady, aOutData, aStall);
      end
    end
    aInValid = 1'b0;
    aEn      = 1'b1;
    #1;
    totalChecks++;
    if (aOutValid !== 1'b1 || aOutData !== 8'h77) begin
      badChecks++;
      $display("[TB] FAIL en_resume got v=%b d=%h exp v=1 d=77", aOutValid, aOutData);
    end
    tick();
    totalChecks++;
    if (aOutValid !== 1'b0) begin badChecks++; $display("[TB] FAIL en_drain got=%b exp=0", aOutValid); end
  endtask

  task automatic test_saturate;
    logic [1:0] expCnt [0:5];
    expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    bOutReady = 1'b0;
    bInValid  = 1'b1;
    bInData   = 8'h5A;
    tick();
    bInValid = 1'b0;
    totalChecks++;
    if (bOutData !== 8'h5A || cOutData !== 8'h5A) begin
      badChecks++;
      $display("[TB] FAIL sat_load got b=%h c=%h exp 5A", bOutData, cOutData);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      totalChecks++;
      if (bStall !== expCnt[i] || cStall !== expCnt[i]) begin
        badChecks++;
        $display("[TB] FAIL sat_cnt[%0d] got b=%0d c=%0d exp=%0d", i, bStall, cStall, expCnt[i]);
      end
      totalChecks++;
      if (bInReady !== 1'b1 || cInReady !== 1'b0) begin
        badChecks++;
        $display("[TB] FAIL sat_ready[%0d] got b=%b c=%b exp b=1 c=0", i, bInReady, cInReady);
      end
    end
  endtask

  task automatic test_comb_ready;
    bOutReady = 1'b1;
    #1;
    totalChecks++;
    if (cInReady !== 1'b1) begin badChecks++; $display("[TB] FAIL comb_ready_hi got=%b exp=1", cInReady); end
    bOutReady = 1'b0;
    #1;
    totalChecks++;
    if (cInReady !== 1'b0) begin badChecks++; $display("[TB] FAIL comb_ready_lo got=%b exp=0", cInReady); end
    bOutReady = 1'b1;
    bInValid  = 1'b1;
    bInData   = 8'hC1;
    tick();
    bInValid = 1'b0;
    totalChecks++;
    if (cOutData !== 8'hC1 || bOutData !== 8'hC1 || cOutValid !== 1'b1 || bOutValid !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL b2b_pass got b=%h c=%h exp C1", bOutData, cOutData);
    end
    totalChecks++;
    if (cStall !== 2'd3) begin badChecks++; $display("[TB] FAIL b2b_stall got=%0d exp=3", cStall); end
    tick();
    totalChecks++;
    if (cOutValid !== 1'b0 || bOutValid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL b2b_drain got b=%b c=%b exp 0", bOutValid, cOutValid);
    end
    bOutReady = 1'b0;
    bInValid  = 1'b1;
    bInData   = 8'hD1;
    tick();
    bInValid = 1'b0;
    tick();
    bRst = 1'b1;
    tick();
    bRst = 1'b0;
    totalChecks++;
    if (cStall !== 2'd0 || cOutValid !== 1'b0 || bStall !== 2'd0) begin
      badChecks++;
      $display("[TB] FAIL rst_mid got c=%0d/%b b=%0d exp 0", cStall, cOutValid, bStall);
    end
    bInValid  = 1'b1;
    bInData   = 8'hE2;
    bOutReady = 1'b1;
    tick();
    bInValid = 1'b0;
    totalChecks++;
    if (cOutData !== 8'hE2 || cOutValid !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL rst_next got v=%b d=%h exp v=1 d=E2", cOutValid, cOutData);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_enable();
    test_saturate();
    test_comb_ready();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core; generalises the fixed EX/MEM latch.
- Carries a flat WIDTH-bit payload with a valid/ready handshake, optional skid slot, flush and global enable.
- Also provides a saturating stall-cycle counter.
- Instantiated between any two stages: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- WIDTH, 64, payload width in bits; must be >= 1.
- SKID, 1, 0 = single slot (in_ready combinational from out_ready), 1 = two slots (in_ready registered, no ready path through the stage).
- CLEAR_DATA, 1, 1 = reset and flush zero the payload registers, 0 = only valid bits are cleared.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries and any same-cycle input.
- en  in  1  global enable; low = freeze stage.
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage accepts payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage presents payload.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  presented payload; always from the main slot.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (RST=1 at edge):
  - main_v=0, skid_v=0, stall_cnt=0.
  - main/skid data=0 if CLEAR_DATA=1.
  - Therefore out_valid=0 and out_data=0 (CLEAR_DATA=1); in_ready=1 once en=1.
  - Reset overrides flush and en.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload is only sampled on in_fire.
  - out_data is stable while out_valid=1 and out_ready=0.
- en=0:
  - in_ready=0 and out_valid=0 (combinational gating).
  - All slots hold; stall_cnt holds.
  - No transfer occurs.
- flush=1 (not reset):
  - main_v=0, skid_v=0; data zeroed if CLEAR_DATA=1.
  - Any in_fire that cycle is dropped; stall_cnt holds.
  - Flush beats en=0.
- SKID=0:
  - in_ready = en & (!main_v | out_ready).
  - on in_fire: main <= in_data, main_v=1.
  - else on out_fire: main_v=0.
  - Latency 1 cycle; full throughput.
- SKID=1:
  - in_ready = en & !skid_v; registered state only.
  - main empty + in_fire: load main.
  - main full + out_fire + in_fire: main <= in_data.
  - main full + no out_fire + in_fire: skid <= in_data, skid_v=1.
  - out_fire with skid_v=1: main <= skid, skid_v=0; a new input cannot arrive that cycle because in_ready=0.
  - Ordering is strictly FIFO. Latency 1 cycle; full throughput in steady state.
- stall_cnt: increments when en & main_v & !out_ready & !flush; saturates at 2^CNT_W-1 without wrapping.
- Simultaneous in_fire and out_fire on an empty skid: no bubble, no duplicate, no loss.
- Reset or flush mid-stall discards held entries; the first payload accepted afterwards is the next one out.

Decomposition:
- Package pipe_pkg:
  - typedef struct packed per stage boundary, e.g. exmem_t with fields outputo, zeroo, wdato, dWENo, dRENo, WENo, wselo, reg_wro, write_sigo, halto, brvalo, beqo, bneo, jsigo, jrsigo, pcAddrOuto, laddro.
  - localparam widths of each struct, used for WIDTH via $bits.
- Sub-module pipe_slot: one WIDTH-bit data + valid register with load/clear/hold and CLEAR_DATA handling. Instantiated once (SKID=0) or twice (SKID=1) via generate.

Test Plan:
- WIDTH=8, SKID=1: hold RST=1 two cycles with in_valid=1, in_data=8'hAA -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 after release.
- Stream 8'h01..8'h08, one per cycle, out_ready=1 -> out_data 01..08 one cycle after each input; no gaps; stall_cnt=0.
- Send 8'h11, 8'h22 with out_ready=0 -> in_ready drops after the second; stall_cnt counts 1,2,3. Raise out_ready -> 11 then 22, in order, no loss.
- Main=8'h33 and skid=8'h44, assert flush together with in_valid=1, in_data=8'h55 -> next cycle out_valid=0, out_data=0, 55 not accepted; then 8'h66 passes normally.
- en=0 for 3 cycles with main=8'h77 and out_ready=1 -> out_valid=0, in_ready=0, value retained, stall_cnt unchanged; en=1 -> 77 delivered.
- CNT_W=2, out_ready=0 for 6 cycles with main_v=1 -> stall_cnt 1,2,3,3,3,3. Repeat with SKID=0 -> in_ready follows out_ready combinationally.
